// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and helpers for the programmable clock divider
package clk_div_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    PARK = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 32;
  localparam int TERM_W    = 64;

  // A programmed half-period of zero behaves as one: toggle every cycle.
  function automatic logic [TERM_W-1:0] eff_term(input logic [TERM_W-1:0] half);
    return (half == '0) ? TERM_W'(1) : half;
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable clock divider with toggle/rise ticks
// Optional build macro CLK_DIV_PARK_LOW_EN: stops always park with clk_out low.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = 50000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_half_in,
  input  logic             div_load,
  output logic             div_pend,
  output logic             clk_out,
  output logic             tick,
  output logic             rise_tick
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_half_q, active_half_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic             div_pend_q, div_pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             rise_tick_q, rise_tick_d;

  logic [CNT_W-1:0] term;
  logic             at_term;
  logic             park_go;
  logic             counting;

  assign term    = CNT_W'(eff_term(TERM_W'(active_half_q)));
  assign at_term = (cnt_q >= (term - CNT_W'(1)));

`ifdef CLK_DIV_PARK_LOW_EN
  // A stop requested while clk_out is high keeps counting until the falling toggle.
  assign park_go = clk_out_q && (state_q != HOLD);
`else
  assign park_go = 1'b0;
`endif

  assign counting = en || park_go;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      active_half_q <= CNT_W'(DEFAULT_HALF);
      pend_half_q   <= '0;
      div_pend_q    <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      rise_tick_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_half_q <= active_half_d;
      pend_half_q   <= pend_half_d;
      div_pend_q    <= div_pend_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      rise_tick_q   <= rise_tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD: if (en) state_d = RUN;
      RUN: begin
        if (!en) begin
          state_d = (park_go && !at_term) ? PARK : HOLD;
        end
      end
`ifdef CLK_DIV_PARK_LOW_EN
      PARK: begin
        if (en) state_d = RUN;
        else if (at_term) state_d = HOLD;
      end
`endif
      default: state_d = en ? RUN : HOLD;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    clk_out_d     = clk_out_q;
    tick_d        = 1'b0;
    rise_tick_d   = 1'b0;
    active_half_d = active_half_q;
    pend_half_d   = pend_half_q;
    div_pend_d    = div_pend_q;

    if (counting) begin
      if (at_term) begin
        cnt_d       = '0;
        clk_out_d   = ~clk_out_q;
        tick_d      = 1'b1;
        rise_tick_d = ~clk_out_q;
        if (div_pend_q) begin
          active_half_d = pend_half_q;
          div_pend_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A load at a clean low rest point cannot cut a period short, so apply it now.
    if (div_load) begin
      if (!counting && (cnt_q == '0) && !clk_out_q) begin
        active_half_d = div_half_in;
      end else begin
        pend_half_d = div_half_in;
        div_pend_d  = 1'b1;
      end
    end
  end

  assign div_pend  = div_pend_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign rise_tick = rise_tick_q;

endmodule
